// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ======================================================================
// Module   : ex_muldiv_unit_if
// Purpose  : Request/result bundle between the EX stage and the mul/div unit.
// Revision : 1.0
// ======================================================================
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ======================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit feeding HI/LO; optional
//            multiply early-out enabled by MULDIV_EARLY_OUT_EN.
// Revision : 1.0
// ======================================================================
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  ex_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e               state_q,  state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [2*WIDTH-1:0]   opb_q,    opb_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [WIDTH-1:0]     hi_q,     hi_d;
  logic [WIDTH-1:0]     lo_q,     lo_d;
  logic                 done_q,   done_d;

  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 div_by_zero;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic                 last_iter;
  logic                 calc_last;

  assign signed_op   = ~bus.op[0];
  assign a_neg       = signed_op & bus.src_a[WIDTH-1];
  assign b_neg       = signed_op & bus.src_b[WIDTH-1];
  assign a_mag       = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag       = b_neg ? -bus.src_b : bus.src_b;
  assign div_by_zero = bus.op[1] && (bus.src_b == '0);

  // Restoring step: acc holds {remainder, dividend-being-shifted-out/quotient-shifted-in}.
  // A set MSB in div_diff means the trial subtraction borrowed.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q[WIDTH-1:0]};

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  // Once the unconsumed multiplier bits are zero the product is final.
  assign calc_last = last_iter || (!is_div_q && (mplier_q[WIDTH-1:1] == '0));
`else
  assign calc_last = last_iter;
`endif

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          is_div_d = bus.op[1];
          cnt_d    = '0;
          if (div_by_zero) begin
            // Unsigned-looking result with no sign fix: hi=src_a, lo=all ones.
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            acc_d    = {bus.src_a, {WIDTH{1'b1}}};
            state_d  = ST_FIX;
          end else begin
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            acc_d    = bus.op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
            opb_d    = bus.op[1] ? {{WIDTH{1'b0}}, b_mag} : {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            state_d  = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (mplier_q[0]) begin
              acc_d = acc_q + opb_q;
            end
            opb_d    = opb_q << 1;
            mplier_d = mplier_q >> 1;
          end
          if (calc_last) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ======================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Self-checking bench for ex_muldiv_unit against an arithmetic model.
// Revision : 1.0
// ======================================================================
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam int ND = 6;
  logic [1:0]  dir_op [ND] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b01};
  logic [31:0] dir_a  [ND] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5};
  logic [31:0] dir_b  [ND] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd3};
  logic [31:0] dir_hi [ND] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'h0, 32'h0};
  logic [31:0] dir_lo [ND] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd15};

  // Reference arithmetic: 64-bit products and SV's truncating division.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    eh = '0;
    el = '0;
    case (op)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        eh = sp[63:32];
        el = sp[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32];
        el = up[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFFFFFF;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          eh = 32'd0; el = 32'h80000000;
        end else begin
          el = sa / sb;
          eh = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFFFFFF;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endfunction

  // Cycle (start in cycle 0) at which done is expected.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 32;
    m = (!op[0] && b[31]) ? -b : b;
    if (op[1] && b == 32'd0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`endif
    if (m == 32'hFFFF_FFFF) n = n + 0;
    return n + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launches one op in the current cycle (cycle 0), scrambles the inputs afterwards,
  // and returns the cycle where done rose (0 on timeout) and whether busy tracked it.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic busy_ok);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.flush = 1'b0; bus.start = 1'b1;
    cyc = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0;
        bus.op = 2'($urandom_range(0, 3)); bus.src_a = $urandom; bus.src_b = $urandom;
      end
      if (bus.done) begin
        cyc = c;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
  endtask

  task automatic test_directed();
    int   cyc;
    logic bok;
    for (int i = 0; i < ND; i++) begin
      do_op(dir_op[i], dir_a[i], dir_b[i], cyc, bok);
      total++; if (cyc != exp_lat(dir_op[i], dir_b[i])) begin
        bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, cyc, exp_lat(dir_op[i], dir_b[i])); end
      total++; if (bus.hi !== dir_hi[i]) begin bad++; $display("FAIL dir%0d_hi got=%h exp=%h", i, bus.hi, dir_hi[i]); end
      total++; if (bus.lo !== dir_lo[i]) begin bad++; $display("FAIL dir%0d_lo got=%h exp=%h", i, bus.lo, dir_lo[i]); end
      total++; if (bok !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=0 exp=1", i); end
    end
`ifndef MULDIV_EARLY_OUT_EN
    do_op(2'b01, 32'd5, 32'd3, cyc, bok);
    total++; if (cyc != 34) begin bad++; $display("FAIL fixed_latency got=%0d exp=34", cyc); end
`endif
  endtask

  task automatic test_random();
    int          cyc;
    logic        bok;
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      model(op, a, b, eh, el);
      do_op(op, a, b, cyc, bok);
      total++; if (cyc != exp_lat(op, b) || bok !== 1'b1) begin
        bad++; $display("FAIL rnd%0d_timing op=%0d b=%h lat got=%0d exp=%0d busy_ok=%b", i, op, b, cyc, exp_lat(op, b), bok); end
      total++; if (bus.hi !== eh || bus.lo !== el) begin
        bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, op, a, b, bus.hi, bus.lo, eh, el); end
    end
  endtask

  task automatic test_flush();
    int          cyc;
    logic        bok, saw;
    logic [31:0] ph, pl;
    model(2'b01, 32'h1234, 32'h10, ph, pl);
    do_op(2'b01, 32'h1234, 32'h10, cyc, bok);
    total++; if (bus.hi !== ph || bus.lo !== pl) begin
      bad++; $display("FAIL flush_prior got=%h_%h exp=%h_%h", bus.hi, bus.lo, ph, pl); end

    // Flush during CALC.
    saw = 1'b0;
    bus.op = 2'b11; bus.src_a = 32'd50; bus.src_b = 32'd7; bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.done) saw = 1'b1;
    end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_calc_busy10 got=%b exp=1", bus.busy); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_calc_busy11 got=%b exp=0", bus.busy); end
    repeat (40) begin @(negedge clk); if (bus.done) saw = 1'b1; end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL flush_calc_done got=1 exp=0"); end
    total++; if (bus.hi !== ph || bus.lo !== pl) begin
      bad++; $display("FAIL flush_calc_hilo got=%h_%h exp=%h_%h", bus.hi, bus.lo, ph, pl); end

    // Flush during FIX (cycle 33 for a full-length multiply).
    saw = 1'b0;
    bus.op = 2'b01; bus.src_a = 32'd9; bus.src_b = 32'h80000001; bus.start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.done) saw = 1'b1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL flush_fix busy=%b done=%b exp=0/0", bus.busy, bus.done); end
    repeat (10) begin @(negedge clk); if (bus.done) saw = 1'b1; end
    total++; if (saw !== 1'b0 || bus.hi !== ph || bus.lo !== pl) begin
      bad++; $display("FAIL flush_fix_hilo done_seen=%b got=%h_%h exp=%h_%h", saw, bus.hi, bus.lo, ph, pl); end

    // Start and flush together in IDLE: nothing launches.
    saw = 1'b0;
    bus.op = 2'b11; bus.src_a = 32'd9; bus.src_b = 32'd0; bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_flush_busy got=%b exp=0", bus.busy); end
    repeat (5) begin @(negedge clk); if (bus.done) saw = 1'b1; end
    total++; if (saw !== 1'b0 || bus.hi !== ph || bus.lo !== pl) begin
      bad++; $display("FAIL start_flush_hilo done_seen=%b got=%h_%h exp=%h_%h", saw, bus.hi, bus.lo, ph, pl); end

    // Reset mid-operation clears HI/LO and drops the result.
    saw = 1'b0;
    bus.op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      bad++; $display("FAIL midop_reset busy=%b got=%h_%h exp=0 0_0", bus.busy, bus.hi, bus.lo); end
    repeat (40) begin @(negedge clk); if (bus.done) saw = 1'b1; end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL midop_reset_done got=1 exp=0"); end
  endtask

  task automatic test_back_to_back();
    int          cyc_a, cyc_c;
    logic [1:0]  op_a, op_c;
    logic [31:0] a_a, b_a, a_c, b_c, eh_a, el_a, eh_c, el_c;
    op_a = {1'b1, 1'($urandom_range(0, 1))};
    a_a  = $urandom;
    b_a  = $urandom | 32'd1;
    op_c = 2'($urandom_range(0, 3));
    a_c  = pick();
    b_c  = pick();
    model(op_a, a_a, b_a, eh_a, el_a);
    model(op_c, a_c, b_c, eh_c, el_c);

    cyc_a = 0;
    bus.op = op_a; bus.src_a = a_a; bus.src_b = b_a; bus.start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 5) begin
        bus.op = 2'b01; bus.src_a = 32'd77; bus.src_b = 32'd3; bus.start = 1'b1;
      end
      if (c == 6) begin
        bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
      end
      if (bus.done) begin cyc_a = c; break; end
    end
    total++; if (cyc_a != 34) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=34", cyc_a); end
    total++; if (bus.hi !== eh_a || bus.lo !== el_a) begin
      bad++; $display("FAIL b2b_first_result got=%h_%h exp=%h_%h", bus.hi, bus.lo, eh_a, el_a); end

    // Launch in the done cycle.
    cyc_c = 0;
    bus.op = op_c; bus.src_a = a_c; bus.src_b = b_c; bus.start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom; end
      if (bus.done) begin cyc_c = c; break; end
    end
    total++; if (cyc_c != exp_lat(op_c, b_c)) begin
      bad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc_c, exp_lat(op_c, b_c)); end
    total++; if (bus.hi !== eh_c || bus.lo !== el_c) begin
      bad++; $display("FAIL b2b_second_result op=%0d got=%h_%h exp=%h_%h", op_c, bus.hi, bus.lo, eh_c, el_c); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
